// File: rtl/shift_sequencer.sv
// Multi-cycle LSL/LSR/ASR/ROR unit. It applies up to 2^STEP_BITS-1 positions per
// clock and reports through a start/busy/done handshake.
module shift_sequencer #(
  parameter int WIDTH     = 8,
  parameter int AMT_W     = 8,
  parameter int STEP_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int MAX_STEP = (1 << STEP_BITS) - 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR} op_t;

  state_t               state, state_nxt;
  op_t                  op_q;
  logic [WIDTH-1:0]     work, w_nxt;
  logic [AMT_W-1:0]     rem, rem_nxt, eff;
  logic [STEP_BITS-1:0] step;
  logic                 cy, c_nxt;

  // Larger amounts would only repeat a saturated result, so they are clamped.
  always_comb begin
    eff = amount;
    case (op_t'(op))
      OP_LSL, OP_LSR: if (amount > AMT_W'(WIDTH + 1)) eff = AMT_W'(WIDTH + 1);
      OP_ASR:         if (amount > AMT_W'(WIDTH))     eff = AMT_W'(WIDTH);
      default:        eff = amount % AMT_W'(WIDTH);
    endcase
  end

  always_comb begin
    step    = (rem > AMT_W'(MAX_STEP)) ? STEP_BITS'(MAX_STEP) : rem[STEP_BITS-1:0];
    rem_nxt = rem - AMT_W'(step);
    w_nxt   = work;
    c_nxt   = cy;
    for (int i = 0; i < MAX_STEP; i++) begin
      if (i < int'(step)) begin
        case (op_q)
          OP_LSL: begin c_nxt = w_nxt[WIDTH-1]; w_nxt = {w_nxt[WIDTH-2:0], 1'b0}; end
          OP_LSR: begin c_nxt = w_nxt[0]; w_nxt = {1'b0, w_nxt[WIDTH-1:1]}; end
          OP_ASR: begin c_nxt = w_nxt[0]; w_nxt = {w_nxt[WIDTH-1], w_nxt[WIDTH-1:1]}; end
          default: begin c_nxt = w_nxt[0]; w_nxt = {w_nxt[0], w_nxt[WIDTH-1:1]}; end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (rem_nxt == '0) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Visible outputs move only on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      work   <= '0;
      op_q   <= OP_LSL;
      rem    <= '0;
      cy     <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          work <= data_in;
          op_q <= op_t'(op);
          rem  <= eff;
          cy   <= 1'b0;
        end
        S_SHIFT: begin
          work <= w_nxt;
          cy   <= c_nxt;
          rem  <= rem_nxt;
          if (rem_nxt == '0) begin
            result <= w_nxt;
            carry  <= c_nxt;
            zero   <= (w_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
